// File: rtl/cpu_defs.sv
// Shared register-file constants: well-known register indices and reset defaults.
package cpu_defs;
    localparam int          DATA_W  = 32;
    localparam int          ADDR_W  = 5;
    localparam logic [4:0]  REG_X0  = 5'd0;
    localparam logic [4:0]  REG_SP  = 5'd2;
    localparam logic [4:0]  REG_GP  = 5'd3;
    localparam logic [31:0] SP_INIT = 32'h0000_7FFC;
    localparam logic [31:0] GP_INIT = 32'h0000_1800;
endpackage

// File: rtl/regfile_read_mux.sv
// One register read port: applies the hard-wired x0 rule and the optional WB bypass.
// Purely combinational, zero latency; no handshake.
module regfile_read_mux #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int BYPASS_EN = 1
) (
    input  logic [ADDR_W-1:0] rd_idx,
    input  logic [DATA_W-1:0] stored_dat,
    input  logic              wr_vld,
    input  logic [ADDR_W-1:0] wr_idx,
    input  logic [DATA_W-1:0] wr_dat,
    output logic [DATA_W-1:0] rd_dat
);
    always_comb begin
        rd_dat = stored_dat;
        // x0 wins over the bypass so a stray WB write to x0 can never leak out.
        if (rd_idx == '0) begin
            rd_dat = '0;
        end else if ((BYPASS_EN != 0) && wr_vld && (wr_idx == rd_idx)) begin
            rd_dat = wr_dat;
        end
    end
endmodule

// File: rtl/wb_regfile.sv
// RV32I architectural register file: two combinational ID read ports, one registered debug port.
// Writes commit at the clock edge; reads see the committing value via bypass. No backpressure.
module wb_regfile #(
    parameter int                     DATA_W    = cpu_defs::DATA_W,
    parameter int                     ADDR_W    = cpu_defs::ADDR_W,
    parameter logic [DATA_W-1:0]      SP_INIT   = cpu_defs::SP_INIT,
    parameter logic [DATA_W-1:0]      GP_INIT   = cpu_defs::GP_INIT,
    parameter int                     BYPASS_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              WbRegWrite,
    input  logic [ADDR_W-1:0] WbRd,
    input  logic [DATA_W-1:0] WbData,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    input  logic [ADDR_W-1:0] DbgAddr,
    output logic [DATA_W-1:0] DbgData,
    output logic [15:0]       WriteCount
);
    import cpu_defs::REG_X0;
    import cpu_defs::REG_SP;
    import cpu_defs::REG_GP;

    localparam int NUM_REGS = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [15:0]       write_count_q, write_count_d;
    logic [DATA_W-1:0] dbg_data_q, dbg_data_d;
    logic [DATA_W-1:0] dbg_rd_dat;

    function automatic logic [DATA_W-1:0] reset_word(input int idx);
        if (idx == int'(REG_SP)) return SP_INIT;
        if (idx == int'(REG_GP)) return GP_INIT;
        return '0;
    endfunction

    always_comb begin
        regs_d        = regs_q;
        write_count_d = write_count_q;
        dbg_data_d    = dbg_rd_dat;
        if (WbRegWrite && (WbRd != ADDR_W'(REG_X0))) begin
            regs_d[WbRd]  = WbData;
            write_count_d = write_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= reset_word(i);
            end
            write_count_q <= '0;
            dbg_data_q    <= '0;
        end else begin
            regs_q        <= regs_d;
            write_count_q <= write_count_d;
            dbg_data_q    <= dbg_data_d;
        end
    end

    regfile_read_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS_EN(BYPASS_EN)) u_rs1_mux (
        .rd_idx     (ReadReg1),
        .stored_dat (regs_q[ReadReg1]),
        .wr_vld     (WbRegWrite),
        .wr_idx     (WbRd),
        .wr_dat     (WbData),
        .rd_dat     (ReadData1)
    );

    regfile_read_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS_EN(BYPASS_EN)) u_rs2_mux (
        .rd_idx     (ReadReg2),
        .stored_dat (regs_q[ReadReg2]),
        .wr_vld     (WbRegWrite),
        .wr_idx     (WbRd),
        .wr_dat     (WbData),
        .rd_dat     (ReadData2)
    );

    regfile_read_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS_EN(BYPASS_EN)) u_dbg_mux (
        .rd_idx     (DbgAddr),
        .stored_dat (regs_q[DbgAddr]),
        .wr_vld     (WbRegWrite),
        .wr_idx     (WbRd),
        .wr_dat     (WbData),
        .rd_dat     (dbg_rd_dat)
    );

    assign DbgData    = dbg_data_q;
    assign WriteCount = write_count_q;
endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: bypassing and non-bypassing instances share one stimulus stream.
module tb_wb_regfile;
    logic        clk;
    logic        rst;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [4:0]  read_reg1, read_reg2, dbg_addr;
    logic [31:0] rd1_dat, rd2_dat, dbg_dat;
    logic [15:0] wcnt;
    logic [31:0] nb_rd1_dat, nb_rd2_dat, nb_dbg_dat;
    logic [15:0] nb_wcnt;

    typedef enum int {S_RD1, S_RD2, S_DBG, S_WCNT, S_NB_RD1, S_NB_RD2} sel_e;
    typedef struct {
        string       tag;
        sel_e        sel;
        logic [31:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    wb_regfile #(.BYPASS_EN(1)) u_dut (
        .clk(clk), .rst(rst), .WbRegWrite(wb_reg_write), .WbRd(wb_rd), .WbData(wb_data),
        .ReadReg1(read_reg1), .ReadReg2(read_reg2), .ReadData1(rd1_dat), .ReadData2(rd2_dat),
        .DbgAddr(dbg_addr), .DbgData(dbg_dat), .WriteCount(wcnt)
    );

    wb_regfile #(.BYPASS_EN(0)) u_dut_nobyp (
        .clk(clk), .rst(rst), .WbRegWrite(wb_reg_write), .WbRd(wb_rd), .WbData(wb_data),
        .ReadReg1(read_reg1), .ReadReg2(read_reg2), .ReadData1(nb_rd1_dat), .ReadData2(nb_rd2_dat),
        .DbgAddr(dbg_addr), .DbgData(nb_dbg_dat), .WriteCount(nb_wcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic expect_val(input string tag, input sel_e sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        exp_q.push_back(e);
    endtask

    // Sample on the falling edge, away from the rising edge where state moves.
    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.sel)
                S_RD1:    obs = rd1_dat;
                S_RD2:    obs = rd2_dat;
                S_DBG:    obs = dbg_dat;
                S_WCNT:   obs = {16'h0, wcnt};
                S_NB_RD1: obs = nb_rd1_dat;
                default:  obs = nb_rd2_dat;
            endcase
            chk(e.tag, obs, e.exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] reset_val(input int idx);
        if (idx == 2) return 32'h0000_7FFC;
        if (idx == 3) return 32'h0000_1800;
        return 32'h0;
    endfunction

    logic [31:0] last_x1;

    initial begin
        rst          = 1'b1;
        wb_reg_write = 1'b1;
        wb_rd        = 5'd9;
        wb_data      = 32'hA5A5_A5A5;
        read_reg1    = 5'd0;
        read_reg2    = 5'd0;
        dbg_addr     = 5'd0;
        last_x1      = 32'h0;

        // Reset edge with a write of x9 presented: the write must be dropped.
        step();
        rst          = 1'b0;
        wb_reg_write = 1'b0;
        expect_val("rst_wcnt", S_WCNT, 32'h0);
        expect_val("rst_dbg",  S_DBG,  32'h0);
        drain();

        for (int i = 0; i < 32; i++) begin
            read_reg1 = 5'(i);
            read_reg2 = 5'(31 - i);
            expect_val($sformatf("rst_rd1_x%0d", i), S_RD1, reset_val(i));
            expect_val($sformatf("rst_rd2_x%0d", 31 - i), S_RD2, reset_val(31 - i));
            drain();
        end

        // Plain write, visible from storage next cycle.
        step();
        wb_reg_write = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF;
        step();
        wb_reg_write = 1'b0; read_reg1 = 5'd5;
        expect_val("wr_x5_rd1", S_RD1, 32'hDEAD_BEEF);
        expect_val("wr_x5_wcnt", S_WCNT, 32'd1);
        drain();

        // Same-cycle bypass on both ports; non-bypass instance sees the old value.
        step();
        wb_reg_write = 1'b1; wb_rd = 5'd7; wb_data = 32'h1234_5678;
        read_reg1 = 5'd7; read_reg2 = 5'd7;
        expect_val("byp_rd1", S_RD1, 32'h1234_5678);
        expect_val("byp_rd2", S_RD2, 32'h1234_5678);
        expect_val("nobyp_rd1", S_NB_RD1, 32'h0);
        expect_val("nobyp_rd2", S_NB_RD2, 32'h0);
        drain();
        step();
        wb_reg_write = 1'b0;
        expect_val("nobyp_rd1_after", S_NB_RD1, 32'h1234_5678);
        expect_val("byp_wcnt", S_WCNT, 32'd2);
        drain();

        // Write to x0 is ignored, even through the bypass path.
        step();
        wb_reg_write = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF;
        read_reg1 = 5'd0; read_reg2 = 5'd5; dbg_addr = 5'd0;
        expect_val("x0_same_rd1", S_RD1, 32'h0);
        expect_val("x0_same_nb_rd1", S_NB_RD1, 32'h0);
        expect_val("x0_rd2_x5", S_RD2, 32'hDEAD_BEEF);
        drain();
        step();
        wb_reg_write = 1'b0;
        expect_val("x0_next_rd1", S_RD1, 32'h0);
        expect_val("x0_next_dbg", S_DBG, 32'h0);
        expect_val("x0_wcnt", S_WCNT, 32'd2);
        drain();

        // Debug port: stored value, then bypassed value, each one cycle late.
        dbg_addr = 5'd5;
        step();
        expect_val("dbg_x5", S_DBG, 32'hDEAD_BEEF);
        drain();
        step();
        wb_reg_write = 1'b1; wb_rd = 5'd8; wb_data = 32'h0BAD_F00D; dbg_addr = 5'd8;
        step();
        wb_reg_write = 1'b0;
        expect_val("dbg_byp_x8", S_DBG, 32'h0BAD_F00D);
        expect_val("dbg_wcnt", S_WCNT, 32'd3);
        drain();

        // Mid-stream reset with a concurrent write.
        step();
        rst = 1'b1; wb_reg_write = 1'b1; wb_rd = 5'd9; wb_data = 32'hA5A5_A5A5;
        step();
        rst = 1'b0; wb_reg_write = 1'b0; read_reg1 = 5'd9; read_reg2 = 5'd5;
        expect_val("rst2_x9", S_RD1, 32'h0);
        expect_val("rst2_x5", S_RD2, 32'h0);
        expect_val("rst2_wcnt", S_WCNT, 32'h0);
        drain();

        // 65536 writes to x1 wrap the counter back to zero.
        read_reg1 = 5'd1;
        for (int i = 0; i < 65536; i++) begin
            step();
            wb_reg_write = 1'b1; wb_rd = 5'd1; wb_data = $urandom;
            last_x1 = wb_data;
            if (i == 65535) begin
                expect_val("wrap_pre_wcnt", S_WCNT, 32'h0000_FFFF);
                expect_val("wrap_last_byp", S_RD1, last_x1);
                drain();
            end
        end
        step();
        wb_reg_write = 1'b0; dbg_addr = 5'd1;
        expect_val("wrap_wcnt", S_WCNT, 32'h0);
        expect_val("wrap_rd1_x1", S_RD1, last_x1);
        drain();
        step();
        expect_val("wrap_dbg_x1", S_DBG, last_x1);
        drain();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
